// File: rtl/pong_draw_pkg.sv
// Shared types and constants for the pong rectangle draw path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pong_draw_pkg;

    localparam int X_W       = 8;
    localparam int Y_W       = 9;
    localparam int COLOUR_W  = 16;
    localparam int X_MAX_DEF = 239;
    localparam int Y_MAX_DEF = 319;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rect_draw_scheduler_rr_arbiter.sv
// Round-robin grant among draw requesters; optional clear-screen priority (CLEAR_PRIORITY_EN).
// Latency: grant is combinational; pointer moves one edge after grant_take.
// Backpressure: none, the caller only strobes grant_take when it accepts the grant.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             grant_take,
    output logic             gnt_vld,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // First set request at or after the pointer, wrapping; scan from the far end so the nearest wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        cand    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
`ifdef CLEAR_PRIORITY_EN
        // Clear screen overrides rotation so a full-screen wipe is never starved behind sprites.
        if (req[0]) begin
            gnt_vld = 1'b1;
            gnt_idx = '0;
        end
`endif
    end

    // Pointer moves past the winner as soon as it is taken; the next arbitration is only after DONE.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_take && gnt_vld) begin
            ptr_d = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rect_draw_scheduler.sv
// Shares the LCD pixel port between rectangle requesters, scanning X inner / Y outer (CLEAR_PRIORITY_EN gives requester 0 priority).
// Latency: first pixel_valid one cycle after the grant edge; done pulses the cycle after the last pixel.
// Backpressure: pixel_ready low holds pixel_x/y/colour and the scan position stable.
module rect_draw_scheduler
#(
    parameter int N_REQ    = 4,
    parameter int X_MAX    = pong_draw_pkg::X_MAX_DEF,
    parameter int Y_MAX    = pong_draw_pkg::Y_MAX_DEF,
    parameter int COLOUR_W = pong_draw_pkg::COLOUR_W
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [N_REQ-1:0]                   req,
    input  logic [N_REQ*pong_draw_pkg::X_W-1:0] rect_x0,
    input  logic [N_REQ*pong_draw_pkg::X_W-1:0] rect_x1,
    input  logic [N_REQ*pong_draw_pkg::Y_W-1:0] rect_y0,
    input  logic [N_REQ*pong_draw_pkg::Y_W-1:0] rect_y1,
    input  logic [N_REQ*COLOUR_W-1:0]          rect_colour,
    output logic [N_REQ-1:0]                   done,
    output logic                               busy,
    output logic                               pixel_valid,
    input  logic                               pixel_ready,
    output logic [pong_draw_pkg::X_W-1:0]      pixel_x,
    output logic [pong_draw_pkg::Y_W-1:0]      pixel_y,
    output logic [COLOUR_W-1:0]                pixel_colour
);
    import pong_draw_pkg::*;

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  gnt_q, gnt_d;
    logic [X_W-1:0]    x0_q, x0_d, x1_q, x1_d;
    logic [Y_W-1:0]    y1_q, y1_d;
    logic [X_W-1:0]    pixel_x_q, pixel_x_d;
    logic [Y_W-1:0]    pixel_y_q, pixel_y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic              pixel_valid_q, pixel_valid_d;
    logic              busy_q, busy_d;
    logic [N_REQ-1:0]  done_q, done_d;

    logic              gnt_vld;
    logic [IDX_W-1:0]  gnt_idx;
    logic              grant_take;

    logic [X_W-1:0]    x0_sel, x1_sel, x0_c, x1_c;
    logic [Y_W-1:0]    y0_sel, y1_sel, y0_c, y1_c;
    logic [COLOUR_W-1:0] colour_sel;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .grant_take (grant_take),
        .gnt_vld    (gnt_vld),
        .gnt_idx    (gnt_idx)
    );

    // Pick the candidate's rectangle and clamp it onto the panel before it is ever latched.
    always_comb begin
        x0_sel     = rect_x0[int'(gnt_idx)*X_W +: X_W];
        x1_sel     = rect_x1[int'(gnt_idx)*X_W +: X_W];
        y0_sel     = rect_y0[int'(gnt_idx)*Y_W +: Y_W];
        y1_sel     = rect_y1[int'(gnt_idx)*Y_W +: Y_W];
        colour_sel = rect_colour[int'(gnt_idx)*COLOUR_W +: COLOUR_W];
        x0_c = (x0_sel > X_W'(X_MAX)) ? X_W'(X_MAX) : x0_sel;
        x1_c = (x1_sel > X_W'(X_MAX)) ? X_W'(X_MAX) : x1_sel;
        y0_c = (y0_sel > Y_W'(Y_MAX)) ? Y_W'(Y_MAX) : y0_sel;
        y1_c = (y1_sel > Y_W'(Y_MAX)) ? Y_W'(Y_MAX) : y1_sel;
    end

    // Grant/scan/done sequencing; every output is computed here and registered below.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        x0_d          = x0_q;
        x1_d          = x1_q;
        y1_d          = y1_q;
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        colour_d      = colour_q;
        pixel_valid_d = pixel_valid_q;
        done_d        = '0;
        grant_take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    grant_take = 1'b1;
                    gnt_d      = gnt_idx;
                    x0_d       = x0_c;
                    x1_d       = x1_c;
                    y1_d       = y1_c;
                    colour_d   = colour_sel;
                    pixel_x_d  = x0_c;
                    pixel_y_d  = y0_c;
                    if ((x0_c > x1_c) || (y0_c > y1_c)) begin
                        // Nothing to paint: report completion without touching the port.
                        state_d         = DONE;
                        done_d[gnt_idx] = 1'b1;
                    end else begin
                        state_d       = DRAW;
                        pixel_valid_d = 1'b1;
                    end
                end
            end
            DRAW: begin
                if (pixel_valid_q && pixel_ready) begin
                    if (pixel_x_q == x1_q) begin
                        if (pixel_y_q == y1_q) begin
                            state_d       = DONE;
                            pixel_valid_d = 1'b0;
                            done_d[gnt_q] = 1'b1;
                        end else begin
                            pixel_x_d = x0_q;
                            pixel_y_d = pixel_y_q + 1'b1;
                        end
                    end else begin
                        pixel_x_d = pixel_x_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d       = IDLE;
                pixel_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset drops everything, including a draw in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            x0_q          <= '0;
            x1_q          <= '0;
            y1_q          <= '0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            colour_q      <= '0;
            pixel_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            x0_q          <= x0_d;
            x1_q          <= x1_d;
            y1_q          <= y1_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            colour_q      <= colour_d;
            pixel_valid_q <= pixel_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign done         = done_q;
    assign busy         = busy_q;
    assign pixel_valid  = pixel_valid_q;
    assign pixel_x      = pixel_x_q;
    assign pixel_y      = pixel_y_q;
    assign pixel_colour = colour_q;

endmodule

// File: tb/tb_rect_draw_scheduler.sv
// Self-checking bench for rect_draw_scheduler against a queue-based scan/arbitration model.
// Latency: n/a.
// Backpressure: pixel_ready driven fixed or randomly by the bench.
module tb_rect_draw_scheduler;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] rect_x0, rect_x1;
    logic [35:0] rect_y0, rect_y1;
    logic [63:0] rect_colour;
    logic [3:0]  done;
    logic        busy;
    logic        pixel_valid;
    logic        pixel_ready;
    logic [7:0]  pixel_x;
    logic [8:0]  pixel_y;
    logic [15:0] pixel_colour;

    int n_checks;
    int n_fail;
    int model_ptr;
    int exp_x[$], exp_y[$];
    int got_x[$], got_y[$], got_c[$];

    rect_draw_scheduler dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .rect_x0      (rect_x0),
        .rect_x1      (rect_x1),
        .rect_y0      (rect_y0),
        .rect_y1      (rect_y1),
        .rect_colour  (rect_colour),
        .done         (done),
        .busy         (busy),
        .pixel_valid  (pixel_valid),
        .pixel_ready  (pixel_ready),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .pixel_colour (pixel_colour)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_rect(input int i, input int x0, input int x1, input int y0, input int y1, input int col);
        rect_x0[i*8 +: 8]      = x0[7:0];
        rect_x1[i*8 +: 8]      = x1[7:0];
        rect_y0[i*9 +: 9]      = y0[8:0];
        rect_y1[i*9 +: 9]      = y1[8:0];
        rect_colour[i*16 +: 16] = col[15:0];
    endtask

    // Reference arbitration: lowest rotation distance from the pointer wins.
    function automatic int model_grant(input int mask, input int ptr);
`ifdef CLEAR_PRIORITY_EN
        if ((mask & 1) != 0) return 0;
`endif
        for (int k = 0; k < 4; k++) begin
            if (((mask >> ((ptr + k) % 4)) & 1) != 0) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    // Reference scan: clamp to the panel, then rows top to bottom, pixels left to right.
    task automatic model_rect(input int x0, input int x1, input int y0, input int y1);
        int cx0, cx1, cy0, cy1;
        cx0 = (x0 > 239) ? 239 : x0;
        cx1 = (x1 > 239) ? 239 : x1;
        cy0 = (y0 > 319) ? 319 : y0;
        cy1 = (y1 > 319) ? 319 : y1;
        exp_x.delete();
        exp_y.delete();
        for (int y = cy0; y <= cy1; y++) begin
            for (int x = cx0; x <= cx1; x++) begin
                exp_x.push_back(x);
                exp_y.push_back(y);
            end
        end
    endtask

    task automatic do_reset();
        req = 4'b0;
        pixel_ready = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_ptr = 0;
        tick();
    endtask

    // Collect accepted pixels until a done pulse or the cycle budget runs out.
    task automatic drain(input int budget, input bit rnd_ready, output logic [3:0] dmask,
                         output int ncyc, output int nvalid);
        got_x.delete();
        got_y.delete();
        got_c.delete();
        dmask  = 4'b0;
        ncyc   = 0;
        nvalid = 0;
        for (int c = 0; c < budget; c++) begin
            if (rnd_ready) pixel_ready = 1'($urandom_range(0, 1));
            if (pixel_valid) nvalid++;
            if (pixel_valid && pixel_ready) begin
                got_x.push_back(int'(pixel_x));
                got_y.push_back(int'(pixel_y));
                got_c.push_back(int'(pixel_colour));
            end
            tick();
            ncyc++;
            if (done !== 4'b0) begin
                dmask = done;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 4'b1111;
        pixel_ready = 1'b1;
        #3;
        n_checks++;
        if ({done, busy, pixel_valid} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl got done=%b busy=%b valid=%b want 0", done, busy, pixel_valid);
        end
        n_checks++;
        if ({pixel_x, pixel_y, pixel_colour} !== 33'b0) begin
            n_fail++; $display("FAIL reset_pixel got x=%0d y=%0d c=%h want 0", pixel_x, pixel_y, pixel_colour);
        end
        tick();
        tick();
        n_checks++;
        if (pixel_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_hold got valid=%b want 0", pixel_valid);
        end
        req = 4'b0;
        reset = 1'b0;
        model_ptr = 0;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_single();
        int ex[4] = '{10, 11, 10, 11};
        int ey[4] = '{5, 5, 6, 6};
        set_rect(1, 10, 11, 5, 6, 16'hF800);
        pixel_ready = 1'b1;
        req = 4'b0010;
        tick();
        req = 4'b0;
        model_ptr = 2;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (pixel_valid !== 1'b1 || int'(pixel_x) != ex[k] || int'(pixel_y) != ey[k] || pixel_colour !== 16'hF800) begin
                n_fail++;
                $display("FAIL single_pix%0d got v=%b (%0d,%0d) c=%h want v=1 (%0d,%0d) c=f800",
                         k, pixel_valid, pixel_x, pixel_y, pixel_colour, ex[k], ey[k]);
            end
            tick();
        end
        n_checks++;
        if (done !== 4'b0010 || pixel_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL single_done got done=%b v=%b busy=%b want 0010 0 1", done, pixel_valid, busy);
        end
        tick();
        n_checks++;
        if (done !== 4'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_after got done=%b busy=%b want 0000 0", done, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] dm;
        int nc, nv;
        set_rect(1, 10, 11, 5, 6, 16'h07E0);
        pixel_ready = 1'b1;
        req = 4'b0010;
        tick();
        req = 4'b0;
        model_ptr = 2;
        tick();
        pixel_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (pixel_valid !== 1'b1 || pixel_x !== 8'd11 || pixel_y !== 9'd5 || pixel_colour !== 16'h07E0) begin
                n_fail++;
                $display("FAIL bp_hold%0d got v=%b (%0d,%0d) c=%h want v=1 (11,5) c=07e0",
                         k, pixel_valid, pixel_x, pixel_y, pixel_colour);
            end
        end
        pixel_ready = 1'b1;
        drain(40, 1'b0, dm, nc, nv);
        n_checks++;
        if (got_x.size() + 1 != 4 || dm !== 4'b0010) begin
            n_fail++; $display("FAIL bp_count got pixels=%0d done=%b want 4 0010", got_x.size() + 1, dm);
        end
        n_checks++;
        if (got_x.size() == 0 || got_x[0] != 11 || got_y[0] != 5) begin
            n_fail++; $display("FAIL bp_resume got first=(%0d,%0d) want (11,5)", got_x[0], got_y[0]);
        end
        tick();
    endtask

    // Held requests rotate; a second round adds requester 0 to exercise the optional priority.
    task automatic test_round_robin();
        logic [3:0] dm;
        int nc, nv, g;
        int mask;
        do_reset();
        for (int i = 0; i < 4; i++) set_rect(i, 40 + i, 40 + i, 60 + i, 60 + i, 16'h1000 + i);
        pixel_ready = 1'b1;
        for (int ph = 0; ph < 2; ph++) begin
            mask = (ph == 0) ? 4'b1110 : 4'b1111;
            req = mask[3:0];
            for (int k = 0; k < 4; k++) begin
                g = model_grant(mask, model_ptr);
                model_ptr = (g + 1) % 4;
                drain(20, 1'b0, dm, nc, nv);
                n_checks++;
                if (dm !== 4'(1 << g) || got_x.size() != 1 || got_x[0] != 40 + g || got_y[0] != 60 + g
                    || got_c[0] != 32'h1000 + g) begin
                    n_fail++;
                    $display("FAIL rr_p%0d_g%0d got done=%b npix=%0d x=%0d want done=%b x=%0d",
                             ph, k, dm, got_x.size(), got_x[0], 4'(1 << g), 40 + g);
                end
                if (k > 0) begin
                    n_checks++;
                    if (nc != 3) begin
                        n_fail++; $display("FAIL rr_gap_p%0d_%0d got %0d cycles want 3", ph, k, nc);
                    end
                end
            end
            req = 4'b0;
            tick();
            tick();
        end
    endtask

    task automatic test_clamp();
        logic [3:0] dm;
        int nc, nv;
        int g;
        set_rect(3, 235, 250, 318, 330, 16'hABCD);
        model_rect(235, 250, 318, 330);
        pixel_ready = 1'b1;
        req = 4'b1000;
        g = model_grant(8, model_ptr);
        model_ptr = (g + 1) % 4;
        drain(60, 1'b1, dm, nc, nv);
        req = 4'b0;
        n_checks++;
        if (got_x.size() != exp_x.size() || dm !== 4'b1000) begin
            n_fail++; $display("FAIL clamp_count got %0d done=%b want %0d 1000", got_x.size(), dm, exp_x.size());
        end
        n_checks++;
        if (got_x.size() == 0 || got_x[got_x.size()-1] != 239 || got_y[got_y.size()-1] != 319) begin
            n_fail++; $display("FAIL clamp_last got size=%0d want last (239,319)", got_x.size());
        end
        for (int k = 0; k < exp_x.size() && k < got_x.size(); k++) begin
            n_checks++;
            if (got_x[k] != exp_x[k] || got_y[k] != exp_y[k]) begin
                n_fail++; $display("FAIL clamp_pix%0d got (%0d,%0d) want (%0d,%0d)", k, got_x[k], got_y[k], exp_x[k], exp_y[k]);
            end
        end
        tick();
    endtask

    task automatic test_empty();
        logic [3:0] dm;
        int nc, nv;
        set_rect(2, 20, 10, 0, 5, 16'h1234);
        pixel_ready = 1'b1;
        req = 4'b0100;
        drain(20, 1'b0, dm, nc, nv);
        req = 4'b0;
        model_ptr = 3;
        n_checks++;
        if (dm !== 4'b0100 || nv != 0 || nc != 1) begin
            n_fail++; $display("FAIL empty got done=%b valid_cycles=%0d cycles=%0d want 0100 0 1", dm, nv, nc);
        end
        tick();
    endtask

    task automatic test_reset_mid_draw();
        logic [3:0] dm;
        int nc, nv;
        bit saw_done;
        set_rect(2, 4, 7, 8, 11, 16'h5555);
        pixel_ready = 1'b1;
        req = 4'b0100;
        tick();
        req = 4'b0;
        tick();
        tick();
        n_checks++;
        if (pixel_valid !== 1'b1 || pixel_x !== 8'd6 || pixel_y !== 9'd8) begin
            n_fail++; $display("FAIL rmid_pix3 got v=%b (%0d,%0d) want 1 (6,8)", pixel_valid, pixel_x, pixel_y);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({done, busy, pixel_valid, pixel_x, pixel_y, pixel_colour} !== 39'b0) begin
            n_fail++; $display("FAIL rmid_async got done=%b busy=%b v=%b x=%0d y=%0d c=%h want all 0",
                               done, busy, pixel_valid, pixel_x, pixel_y, pixel_colour);
        end
        saw_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done !== 4'b0) saw_done = 1'b1;
        end
        reset = 1'b0;
        model_ptr = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done !== 4'b0 || pixel_valid !== 1'b0) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) begin
            n_fail++; $display("FAIL rmid_nodone got activity after reset want none");
        end
        set_rect(1, 30, 30, 31, 31, 16'h0F0F);
        set_rect(3, 50, 50, 51, 51, 16'hF0F0);
        req = 4'b1010;
        tick();
        req = 4'b0;
        n_checks++;
        if (pixel_valid !== 1'b1 || pixel_x !== 8'd30 || pixel_y !== 9'd31) begin
            n_fail++; $display("FAIL rmid_ptr got v=%b (%0d,%0d) want 1 (30,31)", pixel_valid, pixel_x, pixel_y);
        end
        model_ptr = 2;
        drain(20, 1'b0, dm, nc, nv);
        n_checks++;
        if (dm !== 4'b0010) begin
            n_fail++; $display("FAIL rmid_done got %b want 0010", dm);
        end
        tick();
    endtask

    // Random masks, rectangles and ready; rect inputs are scrambled after the grant to prove latching.
    task automatic test_random();
        int bx0[4], bx1[4], by0[4], by1[4], bc[4];
        int mask, g, col, hx, hy, hc, cyc;
        bit stalled;
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 4; i++) begin
                bx0[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(232, 255) : $urandom_range(0, 200);
                bx1[i] = bx0[i] + $urandom_range(0, 3);
                if (bx1[i] > 255) bx1[i] = 255;
                by0[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(312, 511) : $urandom_range(0, 300);
                by1[i] = by0[i] + $urandom_range(0, 2);
                if (by1[i] > 511) by1[i] = 511;
                if ($urandom_range(0, 7) == 0 && bx0[i] > 0 && bx0[i] <= 239) bx1[i] = bx0[i] - 1;
                bc[i] = $urandom_range(0, 65535);
                set_rect(i, bx0[i], bx1[i], by0[i], by1[i], bc[i]);
            end
            mask = $urandom_range(1, 15);
            g = model_grant(mask, model_ptr);
            model_ptr = (g + 1) % 4;
            model_rect(bx0[g], bx1[g], by0[g], by1[g]);
            col = bc[g];
            req = mask[3:0];
            tick();
            req = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) set_rect(i, $urandom_range(0, 255), $urandom_range(0, 255),
                                                 $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 65535));
            stalled = 1'b0;
            hx = 0; hy = 0; hc = 0;
            for (cyc = 0; cyc < 200; cyc++) begin
                if (done !== 4'b0) break;
                if (stalled) begin
                    n_checks++;
                    if (pixel_valid !== 1'b1 || int'(pixel_x) != hx || int'(pixel_y) != hy || int'(pixel_colour) != hc) begin
                        n_fail++; $display("FAIL rnd%0d_stall got (%0d,%0d) want (%0d,%0d)", t, pixel_x, pixel_y, hx, hy);
                    end
                end
                pixel_ready = 1'($urandom_range(0, 1));
                stalled = pixel_valid && !pixel_ready;
                hx = int'(pixel_x); hy = int'(pixel_y); hc = int'(pixel_colour);
                if (pixel_valid && pixel_ready) begin
                    n_checks++;
                    if (exp_x.size() == 0 || int'(pixel_x) != exp_x[0] || int'(pixel_y) != exp_y[0] || int'(pixel_colour) != col) begin
                        n_fail++; $display("FAIL rnd%0d_pix got (%0d,%0d) c=%h want (%0d,%0d) c=%h left=%0d",
                                           t, pixel_x, pixel_y, pixel_colour, exp_x[0], exp_y[0], col[15:0], exp_x.size());
                    end
                    if (exp_x.size() != 0) begin
                        void'(exp_x.pop_front());
                        void'(exp_y.pop_front());
                    end
                end
                tick();
            end
            req = 4'b0;
            n_checks++;
            if (done !== 4'(1 << g) || exp_x.size() != 0 || busy !== 1'b1) begin
                n_fail++; $display("FAIL rnd%0d_done got done=%b left=%0d busy=%b want %b 0 1", t, done, exp_x.size(), busy, 4'(1 << g));
            end
            tick();
        end
        pixel_ready = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        model_ptr = 0;
        req = 4'b0;
        rect_x0 = '0; rect_x1 = '0; rect_y0 = '0; rect_y1 = '0; rect_colour = '0;
        pixel_ready = 1'b1;
        reset = 1'b1;
        test_reset();
        test_single();
        test_backpressure();
        test_round_robin();
        test_clamp();
        test_empty();
        test_reset_mid_draw();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rect_draw_scheduler.md
Name: rect_draw_scheduler

Overview:
- Shares the single LCD pixel-write port between up to N_REQ drawing requesters: screen clear, ball, left paddle and right paddle.
- Grants one requester at a time (round-robin) and latches its rectangle and colour.
- Sequences the X/Y address scan over that rectangle, one pixel per accepted handshake.
- Sits between game logic and the LCD write driver; replaces free-running address counters for drawing.

Parameters:
N_REQ, 4, number of requesters (index 0 = clear screen)
X_MAX, 239, highest legal X address
Y_MAX, 319, highest legal Y address
COLOUR_W, 16, pixel colour width (RGB565)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
req  in  N_REQ  per-requester draw request, level
rect_x0  in  N_REQ*8  packed left X, requester i at bits [8i+7:8i]
rect_x1  in  N_REQ*8  packed right X, inclusive
rect_y0  in  N_REQ*9  packed top Y, inclusive
rect_y1  in  N_REQ*9  packed bottom Y, inclusive
rect_colour  in  N_REQ*COLOUR_W  packed fill colour
done  out  N_REQ  one-cycle pulse: requester i's rectangle fully written
busy  out  1  high outside IDLE
pixel_valid  out  1  pixel_x/y/colour valid
pixel_ready  in  1  LCD driver accepts pixel when high with pixel_valid
pixel_x  out  8  current X address
pixel_y  out  9  current Y address
pixel_colour  out  COLOUR_W  current colour

Behaviour:
- Reset (async): state=IDLE; done=0, busy=0, pixel_valid=0, pixel_x=0, pixel_y=0, pixel_colour=0; round-robin pointer=0.
- States: IDLE, DRAW, DONE.
- IDLE: if any req bit set at a clock edge, grant the first set bit at or after the pointer, wrapping modulo N_REQ. In the same edge:
  - latch the granted requester's x0/x1/y0/y1/colour;
  - clamp x to X_MAX and y to Y_MAX;
  - set pixel_x=x0, pixel_y=y0;
  - go to DRAW.
- Request-to-first-pixel_valid latency is 1 cycle.
- Empty rectangle (x0>x1 or y0>y1, evaluated after clamping): go directly to DONE with no pixel emitted.
- DRAW: pixel_valid=1.
  - On pixel_valid&&pixel_ready, advance X (inner loop). When pixel_x==x1, wrap X to x0 and increment Y.
  - Handshake at (x1,y1): go to DONE.
  - pixel_ready low: all pixel outputs hold stable.
- DONE: pixel_valid=0; done[granted]=1 for exactly this cycle; pointer=granted+1 mod N_REQ; next state IDLE.
  - Minimum gap between rectangles is 2 cycles: DONE, then an IDLE grant edge.
- busy=1 in DRAW and DONE.
- Latched data: req and rect inputs are ignored after the grant. Requester deassertion or coordinate change mid-draw does not affect the current rectangle.
- A requester holding req high after done is re-granted only when its round-robin turn returns.
- Address counters never exceed X_MAX/Y_MAX; no overflow is possible after clamping.
- Reset asserted mid-DRAW: aborts immediately; no done pulse; the draw is not resumed.

Optional Feature:
- Macro: CLEAR_PRIORITY_EN.
- Defined: requester 0 (clear screen) wins over all others whenever req[0] is set in IDLE, regardless of pointer. The pointer still updates normally for the other requesters.
- Undefined: pure round-robin across all N_REQ.

Decomposition:
- Package pong_draw_pkg holds:
  - state enum {IDLE, DRAW, DONE};
  - constants X_W=8, Y_W=9, COLOUR_W=16;
  - default X_MAX=239, Y_MAX=319.
- Sub-module rr_arbiter (combinational grant from req and pointer, plus pointer register update on a grant_take strobe). It carries the CLEAR_PRIORITY_EN behaviour.

Test Plan:
- Single 2x2 rectangle: req[1], x0=10, x1=11, y0=5, y1=6, pixel_ready=1.
  - Expected pixels (10,5),(11,5),(10,6),(11,6) on consecutive cycles, first one cycle after grant.
  - done[1] pulses the cycle after (11,6).
- Backpressure: same rectangle with pixel_ready low for 3 cycles on the 2nd pixel. Pixel (11,5) and colour hold stable throughout; total pixel count stays 4.
- Round-robin: req=4'b1110 held high, 1x1 rectangles each. Grant order 1,2,3,1. With req[0] also set and CLEAR_PRIORITY_EN defined, 0 is granted first at every IDLE.
- Clamping and empty rectangle:
  - x1=250, y1=330 → last pixel (239,319).
  - x0=20, x1=10 → done pulse with zero pixel_valid cycles.
- Reset mid-draw: assert reset during pixel 3 of a 4x4 rectangle. All outputs 0 asynchronously, no done pulse, state IDLE; a new req is granted with pointer restarted at 0.
